// File: rtl/usb_rx_fifo.sv
// usb_rx_fifo: first-word-fall-through byte FIFO from usb_uart to the vt52 consumer.
// Registered level drives every status output; a stall counter flags a stuck producer.
module usb_rx_fifo #(
  parameter int DEPTH       = 64,
  parameter int AFULL_LEVEL = 48
) (
  input  logic                     clk_48mhz,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 20;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_LVL   = (AW+1)'(AFULL_LEVEL);
  localparam logic [CW-1:0] OVR_TH   = CW'(DEPTH * 1024);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_init;
  logic [CW-1:0] r_stall;
  logic          r_overrun;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_stall_nx;

  assign w_full      = (r_level == FULL_LVL);
  assign in_ready    = r_init & ~w_full;
  assign out_valid   = (r_level != '0);
  assign almost_full = (r_level >= AF_LVL);
  assign level       = r_level;
  assign overrun     = r_overrun;
  // Gated so stale or never-written storage cannot leak out while empty
  assign out_data    = out_valid ? r_mem[r_rd_ptr] : 8'h00;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk_48mhz) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_init <= 1'b0;
    end else begin
      r_init <= 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - (AW+1)'(1);
      end
    end
  end

  always_comb begin
    w_stall_nx = r_stall;
    if (in_valid && w_full) begin
      if (r_stall != CNT_MAX) begin
        w_stall_nx = r_stall + CW'(1);
      end
    end else if (in_ready) begin
      w_stall_nx = '0;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_stall   <= '0;
      r_overrun <= 1'b0;
    end else if (flush) begin
      r_stall   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_stall <= w_stall_nx;
      if (w_stall_nx >= OVR_TH) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_fifo.sv
// tb_usb_rx_fifo: directed and random stimulus against a queue-based reference.
// Every cycle compares all outputs with the model's view of the FIFO.
module tb_usb_rx_fifo;

  localparam int DEPTH = 64;
  localparam int AFL   = 48;

  logic       clk_48mhz = 1'b0;
  logic       reset_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] level;
  logic       almost_full;
  logic       overrun;

  int vecs = 0;
  int errs = 0;

  logic [7:0] mq[$];
  bit         m_started;
  int         m_stall;
  bit         m_ovr;

  usb_rx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk_48mhz  (clk_48mhz),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .almost_full(almost_full),
    .overrun    (overrun)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    int n;
    n = mq.size();
    chk("level", 32'(level), 32'(n));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("out_data", 32'(out_data), (n != 0) ? 32'(mq[0]) : 32'h0);
    chk("in_ready", 32'(in_ready), 32'(m_started && n < DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= AFL));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic cyc(input logic f, input logic v, input logic [7:0] d,
                     input logic r);
    bit rdy, push, pop, full;
    flush = f; in_valid = v; in_data = d; out_ready = r;
    full = (mq.size() == DEPTH);
    rdy  = m_started && !full;
    push = v && rdy;
    pop  = r && (mq.size() != 0);
    @(posedge clk_48mhz);
    if (reset_n) begin
      if (f) begin
        mq.delete();
        m_stall = 0;
        m_ovr = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(d);
        if (v && full) m_stall++;
        else if (rdy) m_stall = 0;
        if (m_stall >= DEPTH * 1024) m_ovr = 1;
      end
      m_started = 1;
    end
    #1;
    chk_all();
  endtask

  task automatic model_reset();
    mq.delete();
    m_started = 0;
    m_stall = 0;
    m_ovr = 0;
  endtask

  initial begin
    logic [7:0] exp_b;
    reset_n = 1'b0; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    model_reset();
    #2;
    chk_all();
    repeat (2) cyc(0, 1, 8'hAA, 1);
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    #1;
    chk_all();

    // 1: single byte through an empty FIFO
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h41, 1);
    chk("t1_data", 32'(out_data), 32'h41);
    cyc(0, 0, 8'h00, 1);
    chk("t1_empty", 32'(out_valid), 32'h0);

    // 2: fill 0x00..0x3F, try one extra, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'(i), 0);
    chk("t2_full", 32'(level), 32'd64);
    cyc(0, 1, 8'hEE, 0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = 8'(i);
      chk("t2_drain", 32'(out_data), 32'(exp_b));
      cyc(0, 0, 8'h00, 1);
    end

    // 3: steady-state at level 10 across pointer wrap
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'(8'h80 + i), 0);
    for (int i = 0; i < 200; i++) cyc(0, 1, 8'(i), 1);
    chk("t3_level", 32'(level), 32'd10);

    // 4: full, pop with in_valid, then refill
    for (int i = 0; i < DEPTH - 10; i++) cyc(0, 1, 8'(i + 3), 0);
    cyc(0, 1, 8'hC1, 1);
    chk("t4_rdy", 32'(in_ready), 32'h1);
    cyc(0, 1, 8'hC2, 0);
    chk("t4_full", 32'(level), 32'd64);

    // 5: flush at level 20 with push and pop asserted
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 8'(i + 7), 0);
    cyc(1, 1, 8'h99, 1);
    chk("t5_flush", 32'(out_valid), 32'h0);
    cyc(0, 1, 8'h55, 0);
    chk("t5_first", 32'(out_data), 32'h55);

    // 6: stuck producer while full raises sticky overrun
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 1, 8'($urandom), 0);
    for (int i = 0; i < DEPTH * 1024 + 4; i++) cyc(0, 1, 8'h77, 0);
    chk("t6_ovr", 32'(overrun), 32'h1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 8'h00, 1);
    chk("t6_sticky", 32'(overrun), 32'h1);
    for (int i = 0; i < 30; i++) cyc(0, 1, 8'($urandom), 0);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    cyc(0, 1, 8'h12, 1);
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    #1;
    chk_all();

    // random traffic with occasional flush
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          8'($urandom), ($urandom_range(0, 2) == 0) || (i > 1500 && i[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
